// File: rtl/rename_regfile.sv
// rename_regfile
//   Speculative rename map, committed (retirement) map and physical register
//   file with ready bits for the out-of-order core.
//
//   Each cycle it renames RENAME_WIDTH lanes and forwards destinations to
//   younger lanes in the same group. It accepts WB_WIDTH writebacks with
//   same-cycle bypass to readers, and COMMIT_WIDTH retirement map updates.
//   A flush copies the committed map, including this cycle's commits, back
//   into the speculative map.
//
//   Ports (lane/port i of a flattened bus sits at [i*W +: W]):
//     clk, rst                       clock, synchronous active-high reset
//     ren_valid/rs1/rs2/rd/pd        rename request, pd is the freshly allocated tag
//     ren_ps1/ps2                    source physical tags
//     ren_rs1_ready/rs2_ready        source operand available
//     ren_rs1_data/rs2_data          source values, meaningful only when ready
//     ren_pd_old                     previous mapping of rd, for freeing at retire
//     wb_valid/preg/data             result writeback
//     commit_valid/rd/pd             retirement map update
//     flush                          restore speculative map from committed map
module rename_regfile #(
    parameter int PREG_WIDTH   = 6,
    parameter int AREG_WIDTH   = 5,
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_AREG     = 32,
    parameter int NUM_PREG     = 64,
    parameter int RENAME_WIDTH = 2,
    parameter int WB_WIDTH     = 2,
    parameter int COMMIT_WIDTH = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [RENAME_WIDTH-1:0]            ren_valid,
    input  logic [RENAME_WIDTH*AREG_WIDTH-1:0] ren_rs1,
    input  logic [RENAME_WIDTH*AREG_WIDTH-1:0] ren_rs2,
    input  logic [RENAME_WIDTH*AREG_WIDTH-1:0] ren_rd,
    input  logic [RENAME_WIDTH*PREG_WIDTH-1:0] ren_pd,
    output logic [RENAME_WIDTH*PREG_WIDTH-1:0] ren_ps1,
    output logic [RENAME_WIDTH*PREG_WIDTH-1:0] ren_ps2,
    output logic [RENAME_WIDTH*PREG_WIDTH-1:0] ren_pd_old,
    output logic [RENAME_WIDTH-1:0]            ren_rs1_ready,
    output logic [RENAME_WIDTH-1:0]            ren_rs2_ready,
    output logic [RENAME_WIDTH*DATA_WIDTH-1:0] ren_rs1_data,
    output logic [RENAME_WIDTH*DATA_WIDTH-1:0] ren_rs2_data,
    input  logic [WB_WIDTH-1:0]                wb_valid,
    input  logic [WB_WIDTH*PREG_WIDTH-1:0]     wb_preg,
    input  logic [WB_WIDTH*DATA_WIDTH-1:0]     wb_data,
    input  logic [COMMIT_WIDTH-1:0]            commit_valid,
    input  logic [COMMIT_WIDTH*AREG_WIDTH-1:0] commit_rd,
    input  logic [COMMIT_WIDTH*PREG_WIDTH-1:0] commit_pd,
    input  logic                               flush
);

    logic [PREG_WIDTH-1:0] spec_map_q   [NUM_AREG];
    logic [PREG_WIDTH-1:0] spec_map_d   [NUM_AREG];
    logic [PREG_WIDTH-1:0] commit_map_q [NUM_AREG];
    logic [PREG_WIDTH-1:0] commit_map_d [NUM_AREG];
    logic [NUM_PREG-1:0]   ready_q;
    logic [NUM_PREG-1:0]   ready_d;
    logic [DATA_WIDTH-1:0] data_q       [NUM_PREG];
    logic [DATA_WIDTH-1:0] data_d       [NUM_PREG];

    // Rename lookup: intra-group forwarding, then map + writeback bypass,
    // then the register file itself.
    always_comb begin
        logic [AREG_WIDTH-1:0] src;
        logic [AREG_WIDTH-1:0] dst;
        logic [PREG_WIDTH-1:0] ps;
        logic [PREG_WIDTH-1:0] pd_old;
        logic                  fwd;
        logic                  rdy;
        logic [DATA_WIDTH-1:0] dat;

        ren_ps1       = '0;
        ren_ps2       = '0;
        ren_pd_old    = '0;
        ren_rs1_ready = '0;
        ren_rs2_ready = '0;
        ren_rs1_data  = '0;
        ren_rs2_data  = '0;
        src    = '0;
        dst    = '0;
        ps     = '0;
        pd_old = '0;
        fwd    = 1'b0;
        rdy    = 1'b0;
        dat    = '0;

        for (int i = 0; i < RENAME_WIDTH; i++) begin
            for (int k = 0; k < 2; k++) begin
                src = (k == 0) ? ren_rs1[i*AREG_WIDTH +: AREG_WIDTH]
                               : ren_rs2[i*AREG_WIDTH +: AREG_WIDTH];
                ps  = spec_map_q[src];
                fwd = 1'b0;
                rdy = 1'b0;
                dat = '0;
                // Ascending scan so the youngest earlier lane overrides.
                for (int j = 0; j < RENAME_WIDTH; j++) begin
                    if (j < i && ren_valid[j] && src != '0 &&
                        ren_rd[j*AREG_WIDTH +: AREG_WIDTH] == src) begin
                        fwd = 1'b1;
                        ps  = ren_pd[j*PREG_WIDTH +: PREG_WIDTH];
                    end
                end
                if (!fwd) begin
                    rdy = ready_q[ps];
                    dat = data_q[ps];
                    // p0 writebacks are dropped, so they must not bypass either.
                    for (int w = 0; w < WB_WIDTH; w++) begin
                        if (wb_valid[w] && ps != '0 &&
                            wb_preg[w*PREG_WIDTH +: PREG_WIDTH] == ps) begin
                            rdy = 1'b1;
                            dat = wb_data[w*DATA_WIDTH +: DATA_WIDTH];
                        end
                    end
                end
                if (k == 0) begin
                    ren_ps1[i*PREG_WIDTH +: PREG_WIDTH]      = ps;
                    ren_rs1_ready[i]                         = rdy;
                    ren_rs1_data[i*DATA_WIDTH +: DATA_WIDTH] = dat;
                end else begin
                    ren_ps2[i*PREG_WIDTH +: PREG_WIDTH]      = ps;
                    ren_rs2_ready[i]                         = rdy;
                    ren_rs2_data[i*DATA_WIDTH +: DATA_WIDTH] = dat;
                end
            end

            dst    = ren_rd[i*AREG_WIDTH +: AREG_WIDTH];
            pd_old = spec_map_q[dst];
            for (int j = 0; j < RENAME_WIDTH; j++) begin
                if (j < i && ren_valid[j] && dst != '0 &&
                    ren_rd[j*AREG_WIDTH +: AREG_WIDTH] == dst) begin
                    pd_old = ren_pd[j*PREG_WIDTH +: PREG_WIDTH];
                end
            end
            ren_pd_old[i*PREG_WIDTH +: PREG_WIDTH] = pd_old;
        end
    end

    // Next state. Order matters: writeback sets ready, then a rename clear
    // on the same preg wins; flush takes the committed map after this
    // cycle's commits and drops this cycle's renames.
    always_comb begin
        spec_map_d   = spec_map_q;
        commit_map_d = commit_map_q;
        ready_d      = ready_q;
        data_d       = data_q;

        for (int w = 0; w < WB_WIDTH; w++) begin
            if (wb_valid[w] && wb_preg[w*PREG_WIDTH +: PREG_WIDTH] != '0) begin
                data_d[wb_preg[w*PREG_WIDTH +: PREG_WIDTH]]  = wb_data[w*DATA_WIDTH +: DATA_WIDTH];
                ready_d[wb_preg[w*PREG_WIDTH +: PREG_WIDTH]] = 1'b1;
            end
        end

        for (int c = 0; c < COMMIT_WIDTH; c++) begin
            if (commit_valid[c] && commit_rd[c*AREG_WIDTH +: AREG_WIDTH] != '0) begin
                commit_map_d[commit_rd[c*AREG_WIDTH +: AREG_WIDTH]] =
                    commit_pd[c*PREG_WIDTH +: PREG_WIDTH];
            end
        end

        if (flush) begin
            spec_map_d = commit_map_d;
            ready_d    = '1;
        end else begin
            for (int l = 0; l < RENAME_WIDTH; l++) begin
                if (ren_valid[l] && ren_rd[l*AREG_WIDTH +: AREG_WIDTH] != '0) begin
                    spec_map_d[ren_rd[l*AREG_WIDTH +: AREG_WIDTH]] = ren_pd[l*PREG_WIDTH +: PREG_WIDTH];
                    ready_d[ren_pd[l*PREG_WIDTH +: PREG_WIDTH]]    = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int a = 0; a < NUM_AREG; a++) begin
                spec_map_q[a]   <= PREG_WIDTH'(a);
                commit_map_q[a] <= PREG_WIDTH'(a);
            end
            ready_q <= '1;
            for (int p = 0; p < NUM_PREG; p++) begin
                data_q[p] <= '0;
            end
        end else begin
            spec_map_q   <= spec_map_d;
            commit_map_q <= commit_map_d;
            ready_q      <= ready_d;
            data_q       <= data_d;
        end
    end

endmodule

// File: tb/tb_rename_regfile.sv
// Bench for rename_regfile: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a behavioural
// model of the maps and register file.
module tb_rename_regfile;
    localparam int PW = 6, AW = 5, DW = 32, NA = 32, NP = 64, RW = 2, WW = 2, CW = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [RW-1:0]    ren_valid;
    logic [RW*AW-1:0] ren_rs1, ren_rs2, ren_rd;
    logic [RW*PW-1:0] ren_pd, ren_ps1, ren_ps2, ren_pd_old;
    logic [RW-1:0]    ren_rs1_ready, ren_rs2_ready;
    logic [RW*DW-1:0] ren_rs1_data, ren_rs2_data;
    logic [WW-1:0]    wb_valid;
    logic [WW*PW-1:0] wb_preg;
    logic [WW*DW-1:0] wb_data;
    logic [CW-1:0]    commit_valid;
    logic [CW*AW-1:0] commit_rd;
    logic [CW*PW-1:0] commit_pd;
    logic             flush;

    always #5 clk = ~clk;

    rename_regfile #(
        .PREG_WIDTH(PW), .AREG_WIDTH(AW), .DATA_WIDTH(DW), .NUM_AREG(NA),
        .NUM_PREG(NP), .RENAME_WIDTH(RW), .WB_WIDTH(WW), .COMMIT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .ren_valid(ren_valid), .ren_rs1(ren_rs1), .ren_rs2(ren_rs2), .ren_rd(ren_rd),
        .ren_pd(ren_pd), .ren_ps1(ren_ps1), .ren_ps2(ren_ps2), .ren_pd_old(ren_pd_old),
        .ren_rs1_ready(ren_rs1_ready), .ren_rs2_ready(ren_rs2_ready),
        .ren_rs1_data(ren_rs1_data), .ren_rs2_data(ren_rs2_data),
        .wb_valid(wb_valid), .wb_preg(wb_preg), .wb_data(wb_data),
        .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_pd(commit_pd),
        .flush(flush)
    );

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Behavioural model state.
    int          m_spec   [NA];
    int          m_commit [NA];
    bit          m_ready  [NP];
    logic [31:0] m_data   [NP];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ps1(int l);   return 32'(ren_ps1[l*PW +: PW]);    endfunction
    function automatic logic [31:0] ps2(int l);   return 32'(ren_ps2[l*PW +: PW]);    endfunction
    function automatic logic [31:0] pdo(int l);   return 32'(ren_pd_old[l*PW +: PW]); endfunction
    function automatic logic [31:0] rdy1(int l);  return 32'(ren_rs1_ready[l]);       endfunction
    function automatic logic [31:0] rdy2(int l);  return 32'(ren_rs2_ready[l]);       endfunction
    function automatic logic [31:0] dat1(int l);  return ren_rs1_data[l*DW +: DW];    endfunction
    function automatic logic [31:0] dat2(int l);  return ren_rs2_data[l*DW +: DW];    endfunction

    function automatic int lane_rd(int j); return int'(ren_rd[j*AW +: AW]); endfunction
    function automatic int lane_pd(int j); return int'(ren_pd[j*PW +: PW]); endfunction

    // What a source lookup must return, from the rules alone.
    function automatic void exp_src(input int lane, input int s,
                                    output int ps, output bit rdy, output logic [31:0] d);
        bit hit = 0;
        ps  = m_spec[s];
        rdy = m_ready[ps];
        d   = m_data[ps];
        for (int j = lane - 1; j >= 0 && !hit; j--) begin
            if (ren_valid[j] && s != 0 && lane_rd(j) == s) begin
                hit = 1; ps = lane_pd(j); rdy = 0; d = 0;
            end
        end
        if (!hit) begin
            for (int w = WW - 1; w >= 0; w--) begin
                if (wb_valid[w] && ps != 0 && int'(wb_preg[w*PW +: PW]) == ps) begin
                    rdy = 1; d = wb_data[w*DW +: DW];
                    break;
                end
            end
        end
    endfunction

    function automatic int exp_pd_old(input int lane);
        int r = lane_rd(lane);
        if (r == 0) return m_spec[0];
        for (int j = lane - 1; j >= 0; j--)
            if (ren_valid[j] && lane_rd(j) == r) return lane_pd(j);
        return m_spec[r];
    endfunction

    task automatic model_reset();
        for (int a = 0; a < NA; a++) begin m_spec[a] = a; m_commit[a] = a; end
        for (int p = 0; p < NP; p++) begin m_ready[p] = 1; m_data[p] = 0; end
    endtask

    // Advance the model across one rising edge using the inputs of that cycle.
    task automatic model_step();
        if (rst) begin
            model_reset();
        end else begin
            for (int w = 0; w < WW; w++) begin
                int p = int'(wb_preg[w*PW +: PW]);
                if (wb_valid[w] && p != 0) begin m_data[p] = wb_data[w*DW +: DW]; m_ready[p] = 1; end
            end
            for (int c = 0; c < CW; c++) begin
                int r = int'(commit_rd[c*AW +: AW]);
                if (commit_valid[c] && r != 0) m_commit[r] = int'(commit_pd[c*PW +: PW]);
            end
            if (flush) begin
                for (int a = 0; a < NA; a++) m_spec[a] = m_commit[a];
                for (int p = 0; p < NP; p++) m_ready[p] = 1;
            end else begin
                for (int l = 0; l < RW; l++) begin
                    if (ren_valid[l] && lane_rd(l) != 0) begin
                        m_spec[lane_rd(l)] = lane_pd(l);
                        m_ready[lane_pd(l)] = 0;
                    end
                end
            end
        end
    endtask

    // Compare process: every cycle, every lane, against the model.
    always @(negedge clk) begin
        int ps; bit r; logic [31:0] d;
        if (chk_en) begin
            for (int i = 0; i < RW; i++) begin
                exp_src(i, int'(ren_rs1[i*AW +: AW]), ps, r, d);
                chk("m_ps1", ps1(i), ps);
                chk("m_rdy1", rdy1(i), 32'(r));
                if (r) chk("m_dat1", dat1(i), d);
                exp_src(i, int'(ren_rs2[i*AW +: AW]), ps, r, d);
                chk("m_ps2", ps2(i), ps);
                chk("m_rdy2", rdy2(i), 32'(r));
                if (r) chk("m_dat2", dat2(i), d);
                chk("m_pd_old", pdo(i), exp_pd_old(i));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic clr();
        rst = 0; flush = 0;
        ren_valid = '0; ren_rs1 = '0; ren_rs2 = '0; ren_rd = '0; ren_pd = '0;
        wb_valid = '0; wb_preg = '0; wb_data = '0;
        commit_valid = '0; commit_rd = '0; commit_pd = '0;
    endtask

    task automatic lane(input int l, input bit v, input int rs1, input int rs2, input int rd, input int pd);
        ren_valid[l]        = v;
        ren_rs1[l*AW +: AW] = AW'(rs1);
        ren_rs2[l*AW +: AW] = AW'(rs2);
        ren_rd[l*AW +: AW]  = AW'(rd);
        ren_pd[l*PW +: PW]  = PW'(pd);
    endtask

    task automatic wb(input int port, input int p, input logic [31:0] d);
        wb_valid[port] = 1; wb_preg[port*PW +: PW] = PW'(p); wb_data[port*DW +: DW] = d;
    endtask

    task automatic cm(input int port, input int r, input int p);
        commit_valid[port] = 1; commit_rd[port*AW +: AW] = AW'(r); commit_pd[port*PW +: PW] = PW'(p);
    endtask

    function automatic int rnd_areg();
        return ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, NA - 1));
    endfunction

    function automatic bit busy(input int p);
        for (int l = 0; l < RW; l++)
            if (ren_valid[l] && lane_rd(l) != 0 && lane_pd(l) == p) return 1;
        return 0;
    endfunction

    initial begin
        int pd0, pd1, p;
        clr();
        rst = 1;
        cyc();
        cyc();
        chk_en = 1;

        // Reset state seen through a rename.
        clr(); lane(0, 1, 5, 0, 3, 40); #1;
        chk("rst_ps1", ps1(0), 5);
        chk("rst_rdy1", rdy1(0), 1);
        chk("rst_dat1", dat1(0), 0);
        chk("rst_ps2", ps2(0), 0);
        chk("rst_pd_old", pdo(0), 3);
        cyc(); clr(); lane(0, 0, 3, 0, 0, 0); #1;
        chk("rn_next_ps1", ps1(0), 40);
        chk("rn_next_rdy1", rdy1(0), 0);

        // Intra-group forwarding.
        cyc(); clr(); lane(0, 1, 0, 0, 7, 50); lane(1, 1, 7, 0, 7, 51); #1;
        chk("ig_ps1", ps1(1), 50);
        chk("ig_rdy1", rdy1(1), 0);
        chk("ig_pd_old", pdo(1), 50);
        cyc(); clr(); lane(0, 1, 7, 0, 7, 50); #1;
        chk("ig_map", ps1(0), 51);

        // Writeback bypass, then the array.
        cyc(); clr(); lane(0, 0, 7, 0, 0, 0); wb(0, 50, 32'hDEAD); #1;
        chk("byp_ps1", ps1(0), 50);
        chk("byp_rdy1", rdy1(0), 1);
        chk("byp_dat1", dat1(0), 32'hDEAD);
        cyc(); clr(); lane(0, 0, 7, 0, 0, 0); #1;
        chk("arr_rdy1", rdy1(0), 1);
        chk("arr_dat1", dat1(0), 32'hDEAD);

        // Flush restores the committed map; rename during flush is dropped.
        cyc(); clr(); cm(0, 7, 50);
        cyc(); clr(); lane(0, 1, 0, 0, 7, 51);
        cyc(); clr(); flush = 1; lane(0, 1, 0, 0, 9, 52);
        cyc(); clr(); lane(0, 0, 7, 9, 0, 0); #1;
        chk("fl_ps1", ps1(0), 50);
        chk("fl_rdy1", rdy1(0), 1);
        chk("fl_dat1", dat1(0), 32'hDEAD);
        chk("fl_ps2", ps2(0), 9);
        chk("fl_rdy2", rdy2(0), 1);

        // x0 handling; p60 is observed through x11.
        cyc(); clr(); lane(0, 1, 0, 0, 11, 60);
        cyc(); clr(); wb(0, 60, 77);
        cyc(); clr(); lane(0, 1, 0, 0, 0, 60); #1;
        chk("x0_pd_old", pdo(0), 0);
        cyc(); clr(); lane(0, 0, 0, 11, 0, 0); wb(0, 0, 123); #1;
        chk("x0_ps1", ps1(0), 0);
        chk("x0_dat_byp", dat1(0), 0);
        chk("x0_rdy1", rdy1(0), 1);
        chk("p60_ps2", ps2(0), 60);
        chk("p60_rdy2", rdy2(0), 1);
        chk("p60_dat2", dat2(0), 77);
        cyc(); clr(); lane(0, 0, 0, 0, 0, 0); #1;
        chk("x0_dat_arr", dat1(0), 0);

        // Duplicate writeback and duplicate commit.
        cyc(); clr(); lane(0, 1, 0, 0, 12, 45);
        cyc(); clr(); lane(0, 0, 12, 0, 0, 0); wb(0, 45, 1); wb(1, 45, 2); #1;
        chk("dup_wb_byp", dat1(0), 2);
        cyc(); clr(); lane(0, 0, 12, 0, 0, 0); cm(0, 4, 20); cm(1, 4, 21); flush = 1; #1;
        chk("dup_wb_arr", dat1(0), 2);
        cyc(); clr(); lane(0, 0, 4, 0, 0, 0); #1;
        chk("dup_cm_ps1", ps1(0), 21);
        chk("dup_cm_rdy1", rdy1(0), 1);

        // Randomized traffic, checked by the compare process.
        for (int n = 0; n < 500; n++) begin
            cyc(); clr();
            rst   = ($urandom_range(0, 149) == 0);
            flush = ($urandom_range(0, 19) == 0);
            pd0 = $urandom_range(1, NP - 1);
            do pd1 = $urandom_range(1, NP - 1); while (pd1 == pd0);
            lane(0, $urandom_range(0, 3) != 0, rnd_areg(), rnd_areg(), rnd_areg(), pd0);
            lane(1, $urandom_range(0, 3) != 0, rnd_areg(), rnd_areg(), rnd_areg(), pd1);
            for (int w = 0; w < WW; w++) begin
                if ($urandom_range(0, 1) == 1) begin
                    do p = $urandom_range(0, NP - 1); while (busy(p));
                    wb(w, p, $urandom);
                end
            end
            if (wb_valid == 2'b11 && $urandom_range(0, 3) == 0) wb_preg[PW +: PW] = wb_preg[0 +: PW];
            for (int c = 0; c < CW; c++)
                if ($urandom_range(0, 2) == 0) cm(c, rnd_areg(), $urandom_range(0, NP - 1));
        end

        cyc();
        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rename_regfile.md
# rename_regfile

Parametrised rename table plus physical register file for the out-of-order core. It renames RENAME_WIDTH instructions per cycle and resolves dependencies inside each rename group. It accepts WB_WIDTH writebacks per cycle with same-cycle bypass, and keeps a committed (retirement) map so that a flush restores the speculative map in one cycle. All state updates are fully synchronous on the rising edge of clk; there are no negedge writes.

## Interface
- PREG_WIDTH, 6, physical tag width
- AREG_WIDTH, 5, architectural index width
- DATA_WIDTH, 32, register data width
- NUM_AREG, 32, architectural registers; x0 is hardwired
- NUM_PREG, 64, physical registers
- RENAME_WIDTH, 2, rename lanes per cycle
- WB_WIDTH, 2, writeback ports
- COMMIT_WIDTH, 2, commit ports
- Lane buses are flattened, with lane i at bits [i*W +: W].
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- ren_valid  in  RENAME_WIDTH  lane i renames this cycle
- ren_rs1, ren_rs2, ren_rd  in  RENAME_WIDTH*AREG_WIDTH  source and destination arch indices
- ren_pd  in  RENAME_WIDTH*PREG_WIDTH  new physical tag from the freelist
- ren_ps1, ren_ps2  out  RENAME_WIDTH*PREG_WIDTH  source physical tags
- ren_pd_old  out  RENAME_WIDTH*PREG_WIDTH  previous mapping of rd, sent to the ROB for freeing
- ren_rs1_ready, ren_rs2_ready  out  RENAME_WIDTH  source operand available
- ren_rs1_data, ren_rs2_data  out  RENAME_WIDTH*DATA_WIDTH  source values, valid only when ready=1
- wb_valid  in  WB_WIDTH; wb_preg  in  WB_WIDTH*PREG_WIDTH; wb_data  in  WB_WIDTH*DATA_WIDTH  result writeback
- commit_valid  in  COMMIT_WIDTH; commit_rd  in  COMMIT_WIDTH*AREG_WIDTH; commit_pd  in  COMMIT_WIDTH*PREG_WIDTH  retirement map update
- flush  in  1  restore the speculative map from the committed map

## Operation
**State**
- spec_map[NUM_AREG]
- commit_map[NUM_AREG]
- ready[NUM_PREG]
- data[NUM_PREG]

**Reset**
- Both maps set to identity (x_i -> p_i).
- All ready bits = 1; all data = 0.
- Outputs are combinational, so at reset: ps = source index, ready = 1, data = 0, pd_old = rd index.

**Rename lookup (combinational)** — lane i, source s; highest priority first:
1. Youngest lane j<i with ren_valid[j], ren_rd[j]==s, s!=0: ps = ren_pd[j], ready = 0.
2. Otherwise ps = spec_map[s]. If a wb_valid port has wb_preg == ps (highest port wins), ready = 1 and data = wb_data.
3. Otherwise ready[ps] and data[ps].

**Rename lookup for rd**
- pd_old = ren_pd of the youngest earlier lane with the same rd, otherwise spec_map[rd].
- rd = 0: pd_old = spec_map[0], and the lane makes no update.

**Rename update (posedge)**
- For each valid lane with rd != 0: spec_map[rd] <= ren_pd and ready[ren_pd] <= 0.
- Same rd on several lanes: the highest lane wins.
- Rename clear beats a writeback set on the same preg.

**Writeback (posedge)**
- data[wb_preg] <= wb_data and ready <= 1.
- wb_preg = 0 is ignored, so x0 always reads 0.
- Duplicate preg across ports: the highest port wins.

**Commit (posedge)**
- commit_map[commit_rd] <= commit_pd.
- rd = 0 is ignored.
- Duplicate rd across ports: the highest port wins.

**Flush (posedge)**
- spec_map <= commit_map, including the same-cycle commit updates.
- All ready bits <= 1.
- Renames in that cycle are discarded.
- Writebacks and commits in that cycle still take effect.

**Reset priority**
- rst beats flush, commit, writeback and rename.
- Reset mid-group discards every update in that cycle.

## Timing
- Rename lookup: 0-cycle combinational. Results are valid in the same cycle as ren_valid.
- Writeback to a reader: 0 cycles, via bypass in the same cycle.
- Rename to a consumer in the next group: 1 cycle.
- Intra-group rename to a consumer: 0 cycles, via lane forwarding.
- Flush: 1 cycle. Renames in the cycle after the flush edge see the restored map.
- No backpressure. Legal freelist allocation is the upstream's responsibility: a preg being renamed must not be written back in the same cycle.

## Test plan
- **Reset:** assert rst, then rename rs1=5, rs2=0, rd=3, pd=40. Required: ps1=5, ready=1, data=0, pd_old=3. Next cycle rs1=3 gives ps1=40 with ready=0.
- **Intra-group:** lane0 rd=7 pd=50; lane1 rs1=7, rd=7, pd=51. Required: lane1 ps1=50 with ready=0, and lane1 pd_old=50. After the edge, spec_map[7]=51.
- **WB bypass:** p50 is pending; in the same cycle, wb p50=0xDEAD and a rename reads x7->p50. Required: ready=1, data=0xDEAD. The next cycle reads the same from the array.
- **Flush:** commit x7->p50, then rename x7->p51, then assert flush. Required: the next lookup of x7 gives p50 with ready=1; the rename asserted during the flush cycle leaves no trace.
- **x0:** rename rd=0 pd=60, then wb p0=123. Required: x0 reads p0, data 0, ready=1; ready[60] is unchanged.
- **Conflicts:** two wb ports target p45 with values 1 and 2. Required: data=2. Commit x4->p20 and x4->p21 in the same cycle. Required: commit_map[4]=21 (check via flush).
